// File: rtl/router_pkg.sv
// Shared constants and helpers for the router input unit.
//   clog2              : ceiling log2, usable in parameter expressions
//   TIE_LOWEST, TIE_RR : tie-break selectors for the bank demux
//   ROUTER_FIFO_SPLIT  : default number of input FIFO banks
//   ROUTER_FIFO_DEPTH  : default entries per input FIFO bank
package router_pkg;

  localparam int TIE_LOWEST = 0;
  localparam int TIE_RR     = 1;

  localparam int ROUTER_FIFO_SPLIT = 4;
  localparam int ROUTER_FIFO_DEPTH = 8;

  // clog2(1) = 0, clog2(8) = 3, clog2(9) = 4
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/demux_min_select.sv
// Combinational rotated argmin over per-bank occupancy counts.
// Scans banks starting at start_i (wrapping modulo NUM_BANKS) and grants the
// first eligible bank holding the smallest count.
//   cnt_i   : flattened counts, bank i at [i*CNT_W +: CNT_W]
//   elig_i  : per-bank eligibility mask
//   start_i : first bank index to scan
//   grant_o : one-hot grant (zero when nothing is eligible)
//   idx_o   : binary index of the granted bank
//   any_o   : at least one bank is eligible
module demux_min_select
  import router_pkg::*;
#(
  parameter  int NUM_BANKS = 4,
  parameter  int CNT_W     = 4,
  localparam int IDX_W     = (NUM_BANKS > 1) ? clog2(NUM_BANKS) : 1
) (
  input  logic [NUM_BANKS*CNT_W-1:0] cnt_i,
  input  logic [NUM_BANKS-1:0]       elig_i,
  input  logic [IDX_W-1:0]           start_i,
  output logic [NUM_BANKS-1:0]       grant_o,
  output logic [IDX_W-1:0]           idx_o,
  output logic                       any_o
);

  logic             found;
  logic [CNT_W-1:0] best;
  int               j;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    best    = '0;
    j       = 0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      j = int'(start_i) + k;
      if (j >= NUM_BANKS) begin
        j = j - NUM_BANKS;
      end
      // Strict less-than keeps the first minimum met in scan order.
      if (elig_i[j] && (!found || (cnt_i[j*CNT_W +: CNT_W] < best))) begin
        found = 1'b1;
        best  = cnt_i[j*CNT_W +: CNT_W];
        idx_o = IDX_W'(j);
      end
    end
    if (found) begin
      grant_o[idx_o] = 1'b1;
    end
    any_o = found;
  end

endmodule

// File: rtl/input_unit_demux_nbank.sv
// Input-unit demux: steers each accepted flit to the least-occupied non-full
// FIFO bank, tracking per-bank occupancy from push/pop strobes.
//   clk, rst_n     : clock, asynchronous active-low reset
//   in_data_valid  : upstream flit valid
//   in_data_ready  : at least one bank has room
//   fifo_read_en   : per-bank pop strobes from the downstream arbiter
//   fifo_write_en  : per-bank push strobe, one-hot on accept, else zero
//   fifo_cnt       : flattened occupancy, bank i at [i*CNT_W +: CNT_W]
//   err_clr        : clears err_underflow (a new underflow wins)
//   err_underflow  : sticky flag, a pop hit an empty bank
module input_unit_demux_nbank
  import router_pkg::*;
#(
  parameter  int NUM_BANKS  = ROUTER_FIFO_SPLIT,
  parameter  int FIFO_DEPTH = ROUTER_FIFO_DEPTH,
  parameter  int TIE_MODE   = TIE_LOWEST,
  localparam int CNT_W      = clog2(FIFO_DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_data_valid,
  output logic                       in_data_ready,
  input  logic [NUM_BANKS-1:0]       fifo_read_en,
  output logic [NUM_BANKS-1:0]       fifo_write_en,
  output logic [NUM_BANKS*CNT_W-1:0] fifo_cnt,
  input  logic                       err_clr,
  output logic                       err_underflow
);

  localparam int               IDX_W   = (NUM_BANKS > 1) ? clog2(NUM_BANKS) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [CNT_W-1:0]           cnt_q [NUM_BANKS];
  logic [CNT_W-1:0]           cnt_d [NUM_BANKS];
  logic [NUM_BANKS*CNT_W-1:0] cnt_flat;
  logic [NUM_BANKS-1:0]       full;
  logic [NUM_BANKS-1:0]       grant;
  logic [NUM_BANKS-1:0]       empty_rd;
  logic [IDX_W-1:0]           sel_idx;
  logic [IDX_W-1:0]           start_idx;
  logic [IDX_W-1:0]           rr_ptr_q;
  logic                       any_elig;
  logic                       accept;
  logic                       err_q;
  logic                       err_d;

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    assign cnt_flat[gi*CNT_W +: CNT_W] = cnt_q[gi];
    // A pop in the same cycle does not reopen a full bank.
    assign full[gi] = (cnt_q[gi] == DEPTH_C);
  end

  assign start_idx = (TIE_MODE == TIE_RR) ? rr_ptr_q : '0;

  demux_min_select #(
    .NUM_BANKS (NUM_BANKS),
    .CNT_W     (CNT_W)
  ) u_min_select (
    .cnt_i   (cnt_flat),
    .elig_i  (~full),
    .start_i (start_idx),
    .grant_o (grant),
    .idx_o   (sel_idx),
    .any_o   (any_elig)
  );

  // Counters are all zero in reset, so ready is naturally 1 there; the
  // explicit rst_n term keeps pushes from escaping while reset is held.
  assign in_data_ready = any_elig;
  assign accept        = in_data_valid & any_elig & rst_n;
  assign fifo_write_en = accept ? grant : '0;

  always_comb begin
    empty_rd = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (fifo_read_en[i] && (cnt_q[i] == '0)) begin
        // Pop at empty saturates; a simultaneous push still lands.
        empty_rd[i] = 1'b1;
        if (fifo_write_en[i]) begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else if (fifo_write_en[i] && !fifo_read_en[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (fifo_read_en[i] && !fifo_write_en[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
    // Setting the flag takes priority over clearing it.
    if (|empty_rd) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        cnt_q[i] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      err_q <= err_d;
    end
  end

  if ((NUM_BANKS > 1) && (TIE_MODE == TIE_RR)) begin : g_rr
    logic [IDX_W-1:0] rr_ptr_d;

    always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (accept) begin
        rr_ptr_d = (sel_idx == IDX_W'(NUM_BANKS - 1)) ? '0 : sel_idx + IDX_W'(1);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rr_ptr_q <= '0;
      end else begin
        rr_ptr_q <= rr_ptr_d;
      end
    end
  end else begin : g_no_rr
    assign rr_ptr_q = '0;
  end

  assign fifo_cnt      = cnt_flat;
  assign err_underflow = err_q;

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_chk
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
      cnt_q[gi] <= DEPTH_C);
  end

  a_grant_matches_idx : assert property (@(posedge clk) disable iff (!rst_n)
    accept |-> fifo_write_en[sel_idx]);

endmodule

// File: tb/tb_input_unit_demux_nbank.sv
module tb_input_unit_demux_nbank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic        clr;
  logic [3:0]  rd;

  logic        rdy0, rdy1;
  logic [3:0]  we0, we1;
  logic [15:0] cnt0, cnt1;
  logic        err0, err1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  input_unit_demux_nbank #(.NUM_BANKS(4), .FIFO_DEPTH(8), .TIE_MODE(0)) u_dut0 (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_data_valid (valid),
    .in_data_ready (rdy0),
    .fifo_read_en  (rd),
    .fifo_write_en (we0),
    .fifo_cnt      (cnt0),
    .err_clr       (clr),
    .err_underflow (err0)
  );

  input_unit_demux_nbank #(.NUM_BANKS(4), .FIFO_DEPTH(8), .TIE_MODE(1)) u_dut1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_data_valid (valid),
    .in_data_ready (rdy1),
    .fifo_read_en  (rd),
    .fifo_write_en (we1),
    .fifo_cnt      (cnt1),
    .err_clr       (clr),
    .err_underflow (err1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    valid = 1'b1;
    rd    = 4'b0000;
    clr   = 1'b0;
    #2;
    chk("reset_cnt", cnt0, 16'h0000);
    chk("reset_err", err0, 1'b0);
    chk("reset_rdy", rdy0, 1'b1);
    chk("reset_we0", we0, 4'b0000);
    chk("reset_we1", we1, 4'b0000);

    // Release reset and fill one entry per bank.
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("fill_we", we0, 32'(1 << k));
      chk("fill_rdy", rdy0, 1'b1);
      @(negedge clk);
    end
    chk("fill_cnt", cnt0, 16'h1111);

    // Round-robin: writes 5 and 6 land on banks 0 and 1.
    #1 chk("rr_we5", we1, 4'b0001);
    @(negedge clk);
    #1 chk("rr_we6", we1, 4'b0010);
    @(negedge clk);
    valid = 1'b0;
    #1;
    chk("rr_cnt0", cnt0, 16'h1122);
    chk("rr_cnt1", cnt1, 16'h1122);
    chk("rr_ptr", u_dut1.rr_ptr_q, 2);

    // Level the counts, then show the two tie modes diverge.
    rd = 4'b0011;
    @(negedge clk);
    rd = 4'b0000;
    #1;
    chk("rr_lvl_cnt", cnt1, 16'h1111);
    chk("rr_ptr_hold", u_dut1.rr_ptr_q, 2);
    valid = 1'b1;
    #1;
    chk("tie_low_we", we0, 4'b0001);
    chk("tie_rr_we", we1, 4'b0100);
    @(negedge clk);
    valid = 1'b0;
    #1;
    chk("rr_ptr_adv", u_dut1.rr_ptr_q, 3);
    chk("tie_low_cnt", cnt0, 16'h1112);
    chk("tie_rr_cnt", cnt1, 16'h1211);

    // Async reset mid-cycle, then preload {3,1,2,1}.
    #1 rst_n = 1'b0;
    #1;
    chk("areset1_cnt", cnt0, 16'h0000);
    chk("areset1_rdy", rdy0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    valid = 1'b1;
    repeat (9) @(negedge clk);
    valid = 1'b0;
    #1 chk("pre_cnt9", cnt0, 16'h2223);
    rd = 4'b1010;
    @(negedge clk);
    rd = 4'b0000;
    #1 chk("pre_cnt", cnt0, 16'h1213);
    valid = 1'b1;
    #1 chk("min_we", we0, 4'b0010);
    @(negedge clk);
    valid = 1'b0;
    #1 chk("min_cnt", cnt0, 16'h1223);

    // Fill every bank to depth; valid stays high against backpressure.
    valid = 1'b1;
    repeat (24) @(negedge clk);
    #1;
    chk("full_cnt", cnt0, 16'h8888);
    chk("full_rdy", rdy0, 1'b0);
    chk("full_we", we0, 4'b0000);
    rd = 4'b0100;
    #1;
    chk("pop_full_rdy", rdy0, 1'b0);
    chk("pop_full_we", we0, 4'b0000);
    @(negedge clk);
    rd = 4'b0000;
    #1;
    chk("after_pop_cnt", cnt0, 16'h8788);
    chk("after_pop_rdy", rdy0, 1'b1);
    chk("after_pop_we", we0, 4'b0100);
    @(negedge clk);
    valid = 1'b0;
    #1 chk("refill_cnt", cnt0, 16'h8888);

    // Underflow handling from a clean state.
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    @(negedge clk);
    rd = 4'b0010;
    #1 chk("uf_pre_err", err0, 1'b0);
    @(negedge clk);
    rd = 4'b0000;
    #1;
    chk("uf_err", err0, 1'b1);
    chk("uf_cnt", cnt0, 16'h0000);
    rd    = 4'b0011;
    valid = 1'b1;
    clr   = 1'b1;
    #1 chk("uf_wr_we", we0, 4'b0001);
    @(negedge clk);
    rd    = 4'b0000;
    valid = 1'b0;
    clr   = 1'b0;
    #1;
    chk("uf_set_over_clr", err0, 1'b1);
    chk("uf_wr_cnt", cnt0, 16'h0001);

    // Build {5,4,4,4} with the error still set, then reset mid-cycle.
    valid = 1'b1;
    repeat (16) @(negedge clk);
    valid = 1'b0;
    #1;
    chk("mid_cnt", cnt0, 16'h4445);
    chk("mid_err", err0, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("areset2_cnt", cnt0, 16'h0000);
    chk("areset2_err", err0, 1'b0);
    chk("areset2_rdy", rdy0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    valid = 1'b1;
    #1 chk("post_rst_we", we0, 4'b0001);
    @(negedge clk);
    valid = 1'b0;
    #1 chk("post_rst_cnt", cnt0, 16'h0001);

    // err_clr on its own clears the flag.
    rd = 4'b0010;
    @(negedge clk);
    rd = 4'b0000;
    #1 chk("clr_pre_err", err0, 1'b1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #1 chk("clr_err", err0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
